// File: rtl/mel_filterbank_if.sv
// mel_filterbank_if: power-stream input and mel-energy output bundle for mel_filterbank.
// Handshake: a mel energy transfers on every rising clk where mel_valid_o && mel_ready_i;
// once mel_valid_o is high, mel_idx_o/mel_data_o hold steady until that transfer.
// The power side has no back-pressure: power_valid_i marks a sample, fft_done_i ends a frame.
interface mel_filterbank_if #(
    parameter int NFFT_LOG2   = 9,
    parameter int POWER_WIDTH = 32,
    parameter int FILT_W      = 5,
    parameter int OUT_WIDTH   = 32
);
    logic                   power_valid_i;
    logic [NFFT_LOG2-1:0]   power_ptr_i;
    logic [POWER_WIDTH-1:0] power_sample_i;
    logic                   fft_done_i;
    logic                   mel_valid_o;
    logic                   mel_ready_i;
    logic [FILT_W-1:0]      mel_idx_o;
    logic [OUT_WIDTH-1:0]   mel_data_o;
    logic                   mel_done_o;
    logic                   overrun_o;

    modport slave (
        input  power_valid_i, power_ptr_i, power_sample_i, fft_done_i, mel_ready_i,
        output mel_valid_o, mel_idx_o, mel_data_o, mel_done_o, overrun_o
    );

    modport master (
        output power_valid_i, power_ptr_i, power_sample_i, fft_done_i, mel_ready_i,
        input  mel_valid_o, mel_idx_o, mel_data_o, mel_done_o, overrun_o
    );
endinterface

// File: rtl/mel_filterbank.sv
// mel_filterbank: weights each FFT power bin into two adjacent triangular filters,
// accumulates per-filter energies and streams them out after fft_done_i.
// Optional feature macro: MEL_LOG2_EN (output packed fixed-point log2 of the energy).
// Filter layout table (built at elaboration): centres every 4 bins up to bin 36, then
// spacing grows by one bin per filter; bins past the last centre taper to the top bin.
module mel_filterbank #(
    parameter int NFFT         = 512,
    parameter int NFFT_LOG2    = $clog2(NFFT),
    parameter int NUM_FILTERS  = 26,
    parameter int POWER_WIDTH  = 32,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACC_WIDTH    = 48,
    parameter int OUT_WIDTH    = 32,
    parameter int FILT_W       = $clog2(NUM_FILTERS + 1)
) (
    input logic             clk,
    input logic             rst_n,
    mel_filterbank_if.slave bus
);
    localparam int NUM_BINS = NFFT / 2 + 1;
    localparam int ONE_W    = 1 << (WEIGHT_WIDTH - 1);
    localparam int PROD_W   = POWER_WIDTH + WEIGHT_WIDTH;
    localparam logic [NFFT_LOG2:0]  NUM_BINS_V = (NFFT_LOG2 + 1)'(NUM_BINS);
    localparam logic [FILT_W-1:0]   LAST_F     = FILT_W'(NUM_FILTERS - 1);
    localparam logic [FILT_W-1:0]   NF_V       = FILT_W'(NUM_FILTERS);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

    function automatic int center(input int k);
        if (k < 10) return 4 * k;
        return 26 + ((k - 5) * (k - 4)) / 2;
    endfunction

    // {filter index f, Q1.15 weight towards f}; the rest of the bin goes to f-1.
    function automatic logic [FILT_W+WEIGHT_WIDTH-1:0] rom_entry(input int b);
        int f, lo, hi, w;
        f = NUM_FILTERS;
        w = 0;
        for (int k = NUM_FILTERS - 1; k >= 0; k--)
            if (center(k) >= b) f = k;
        if (f == 0) begin
            w = ONE_W;
        end else begin
            lo = center(f - 1);
            hi = (f == NUM_FILTERS) ? NUM_BINS - 1 : center(f);
            w  = ((b - lo) * ONE_W) / (hi - lo);
        end
        return {FILT_W'(f), WEIGHT_WIDTH'(w)};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
    endfunction

`ifdef MEL_LOG2_EN
    // [15:10] leading-one position, [9:0] the ten bits below it; 0 and 1 map to 0.
    function automatic logic [OUT_WIDTH-1:0] log2_pack(input logic [31:0] e);
        int pos;
        logic [31:0] norm;
        logic [OUT_WIDTH-1:0] r;
        pos = 0;
        for (int i = 0; i < 32; i++)
            if (e[i]) pos = i;
        norm = e << (31 - pos);
        r = '0;
        if (e > 32'd1) begin
            r[15:10] = 6'(pos);
            r[9:0]   = norm[30:21];
        end
        return r;
    endfunction
`endif

    function automatic logic [OUT_WIDTH-1:0] fmt_energy(input logic [ACC_WIDTH-1:0] a);
        logic [OUT_WIDTH-1:0] s;
        s = (|a[ACC_WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}} : a[OUT_WIDTH-1:0];
`ifdef MEL_LOG2_EN
        return log2_pack(32'(s));
`else
        return s;
`endif
    endfunction

    logic [FILT_W-1:0]       idx_rom [NUM_BINS];
    logic [WEIGHT_WIDTH-1:0] w_rom   [NUM_BINS];
    for (genvar b = 0; b < NUM_BINS; b++) begin : g_rom
        localparam logic [FILT_W+WEIGHT_WIDTH-1:0] ENT = rom_entry(b);
        assign idx_rom[b] = ENT[FILT_W+WEIGHT_WIDTH-1:WEIGHT_WIDTH];
        assign w_rom[b]   = ENT[WEIGHT_WIDTH-1:0];
    end

    state_t                  state_q, state_d;
    logic                    s1_vld_q, s2_vld_q;
    logic [FILT_W-1:0]       s1_f_q, s2_f_q;
    logic [WEIGHT_WIDTH-1:0] s1_w_q;
    logic [POWER_WIDTH-1:0]  s1_p_q;
    logic [ACC_WIDTH-1:0]    s2_hi_q, s2_lo_q;
    logic [ACC_WIDTH-1:0]    acc_q [NUM_FILTERS];
    logic [ACC_WIDTH-1:0]    acc_d [NUM_FILTERS];
    logic                    valid_q, valid_d, done_q, done_d, overrun_q, overrun_d;
    logic [FILT_W-1:0]       idx_q, idx_d, idx_nxt;
    logic [OUT_WIDTH-1:0]    data_q, data_d;
    logic                    acc_clr, in_range, accepting, take, stray;
    logic [PROD_W-1:0]       mul_hi, mul_lo;

    assign in_range  = {1'b0, bus.power_ptr_i} < NUM_BINS_V;
    assign accepting = (state_q == IDLE) || (state_q == ACCUM);
    assign take      = bus.power_valid_i && in_range && accepting;
    assign stray     = bus.power_valid_i && in_range && !accepting;
    assign mul_hi    = PROD_W'(s1_p_q) * PROD_W'(s1_w_q);
    assign mul_lo    = PROD_W'(s1_p_q) * PROD_W'(WEIGHT_WIDTH'(ONE_W) - s1_w_q);
    assign idx_nxt   = idx_q + 1'b1;

    // Two-stage front end: ROM lookup + sample capture, then both truncated products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_f_q   <= '0;
            s1_w_q   <= '0;
            s1_p_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_f_q   <= '0;
            s2_hi_q  <= '0;
            s2_lo_q  <= '0;
        end else begin
            s1_vld_q <= take;
            if (take) begin
                s1_f_q <= idx_rom[bus.power_ptr_i];
                s1_w_q <= w_rom[bus.power_ptr_i];
                s1_p_q <= bus.power_sample_i;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_f_q  <= s1_f_q;
                s2_hi_q <= ACC_WIDTH'(mul_hi >> (WEIGHT_WIDTH - 1));
                s2_lo_q <= ACC_WIDTH'(mul_lo >> (WEIGHT_WIDTH - 1));
            end
        end
    end

    // Single-cycle read-modify-write of the (at most two) filters hit by stage 2.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            for (int i = 0; i < NUM_FILTERS; i++) acc_d[i] = '0;
        end else if (s2_vld_q) begin
            if (s2_f_q < NF_V)
                acc_d[s2_f_q] = sat_add(acc_q[s2_f_q], s2_hi_q);
            if (s2_f_q != '0)
                acc_d[s2_f_q - 1'b1] = sat_add(acc_q[s2_f_q - 1'b1], s2_lo_q);
        end
    end

    // Frame FSM and output register next-state.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        data_d    = data_q;
        done_d    = 1'b0;
        acc_clr   = 1'b0;
        overrun_d = overrun_q | stray;
        case (state_q)
            IDLE: begin
                if (bus.fft_done_i) state_d = DRAIN;
                else if (take)      state_d = ACCUM;
            end
            ACCUM: begin
                if (bus.fft_done_i) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave only once the last sample has reached the accumulators.
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d = OUTPUT;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    data_d  = fmt_energy(acc_q[0]);
                end
            end
            OUTPUT: begin
                if (valid_q && bus.mel_ready_i) begin
                    if (idx_q == LAST_F) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        acc_clr = 1'b1;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = fmt_energy(acc_q[idx_nxt]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++) acc_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            acc_q     <= acc_d;
        end
    end

    assign bus.mel_valid_o = valid_q;
    assign bus.mel_idx_o   = idx_q;
    assign bus.mel_data_o  = data_q;
    assign bus.mel_done_o  = done_q;
    assign bus.overrun_o   = overrun_q;
endmodule

// File: tb/tb_mel_filterbank.sv
// tb_mel_filterbank: scenario tasks for mel_filterbank with a queue-based scoreboard.
module tb_mel_filterbank;
    localparam int NF = 26;
    localparam int FW = 5;
    localparam int OW = 32;
    localparam int EW = FW + OW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mel_filterbank_if #(.NFFT_LOG2(9), .POWER_WIDTH(32), .FILT_W(FW), .OUT_WIDTH(OW)) bus ();

    mel_filterbank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    logic [47:0]   model_acc [NF];
    int stall_err, stall_cnt, done_cnt, hs_cnt;
    bit done_ok;

    // Expected output word for an accumulated energy.
    function automatic logic [OW-1:0] exp_word(input logic [47:0] e);
        logic [31:0] s;
        s = (e > 48'h0000_FFFF_FFFF) ? 32'hFFFF_FFFF : e[31:0];
`ifdef MEL_LOG2_EN
        begin
            int p;
            logic [31:0] fr;
            if (s < 32'd2) return '0;
            p = 31;
            while (!s[p]) p--;
            if (p >= 10) fr = (s >> (p - 10)) & 32'h3FF;
            else         fr = (s << (10 - p)) & 32'h3FF;
            return OW'((p << 10) | int'(fr));
        end
`else
        return s;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NF; i++) model_acc[i] = '0;
    endtask

    // Bins 0..36: filter centres every 4 bins, so bin b sits r/4 of the way to filter f.
    task automatic model_add(input int b, input longint p);
        int f, r;
        if (b == 0) begin
            model_acc[0] += 48'(p);
        end else begin
            f = (b + 3) / 4;
            r = b - 4 * (f - 1);
            model_acc[f]     += 48'((p * r) / 4);
            model_acc[f - 1] += 48'((p * (4 - r)) / 4);
        end
    endtask

    task automatic push_expected();
        for (int f = 0; f < NF; f++) exp_q.push_back({FW'(f), exp_word(model_acc[f])});
        model_clear();
    endtask

    task automatic drive(input bit v, input int ptr, input logic [31:0] p, input bit done);
        @(negedge clk);
        bus.power_valid_i  = v;
        bus.power_ptr_i    = 9'(ptr);
        bus.power_sample_i = p;
        bus.fft_done_i     = done;
    endtask

    // Drives mel_ready_i (mode 0 always, 1 = 1-0-0-1 pattern, 2 random) and records transfers.
    task automatic collect(input int mode, input int stop_after, input bit inject);
        bit rdy, prev_stall;
        logic [EW-1:0] cur, prev_word;
        logic [3:0] pat;
        pat = 4'b1001;
        got_q.delete();
        stall_err = 0; stall_cnt = 0; done_cnt = 0; hs_cnt = 0; done_ok = 0;
        prev_stall = 0; prev_word = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.fft_done_i     = 1'b0;
            bus.power_valid_i  = inject && hs_cnt >= 2 && hs_cnt < 20 && (c % 3 == 0);
            bus.power_ptr_i    = 9'($urandom_range(0, 256));
            bus.power_sample_i = $urandom;
            cur = {bus.mel_idx_o, bus.mel_data_o};
            if (bus.mel_done_o) done_cnt++;
            if (prev_stall && (!bus.mel_valid_o || cur !== prev_word)) stall_err++;
            if (stop_after > 0 && hs_cnt == stop_after) begin
                bus.mel_ready_i = 1'b0;
                break;
            end
            if (hs_cnt == NF) begin
                done_ok = bus.mel_done_o && !bus.mel_valid_o;
                bus.mel_ready_i   = 1'b0;
                bus.power_valid_i = 1'b0;
                break;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[c % 4] : 1'($urandom_range(0, 1));
            bus.mel_ready_i = rdy;
            if (bus.mel_valid_o && rdy) begin
                got_q.push_back(cur);
                hs_cnt++;
            end
            if (bus.mel_valid_o && !rdy) stall_cnt++;
            prev_stall = bus.mel_valid_o && !rdy;
            prev_word  = cur;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.mel_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.mel_valid_o); end
        n_cmp++; if (bus.mel_idx_o !== '0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", bus.mel_idx_o); end
        n_cmp++; if (bus.mel_data_o !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.mel_data_o); end
        n_cmp++; if (bus.mel_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.mel_done_o); end
        n_cmp++; if (bus.overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", bus.overrun_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_bin();
        logic [EW-1:0] e, g;
        drive(1, 10, 32'd1000, 0);
        model_add(10, 1000);
        drive(0, 0, 0, 1);
        push_expected();
        collect(0, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL single_bin word: got %h want %h", g, e); end
        end
        exp_q.delete();
        n_cmp++; if (hs_cnt !== NF) begin n_err++; $display("FAIL single_bin transfers: got %0d want %0d", hs_cnt, NF); end
        n_cmp++; if (!done_ok || done_cnt !== 1) begin n_err++; $display("FAIL single_bin done: got ok=%b pulses=%0d want ok=1 pulses=1", done_ok, done_cnt); end
    endtask

    task automatic test_empty_frame();
        logic [EW-1:0] e, g;
        drive(0, 0, 0, 1);
        push_expected();
        collect(2, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL empty_frame word: got %h want %h", g, e); end
        end
        exp_q.delete();
        n_cmp++; if (hs_cnt !== NF || !done_ok) begin n_err++; $display("FAIL empty_frame transfers: got %0d done=%b want %0d done=1", hs_cnt, done_ok, NF); end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e, g;
        int n, b, pb;
        logic [31:0] p;
        for (int fr = 0; fr < 3; fr++) begin
            n = $urandom_range(5, 25);
            pb = 0;
            for (int i = 0; i < n; i++) begin
                b = (i > 0 && $urandom_range(0, 3) == 0) ? pb : $urandom_range(0, 36);
                p = $urandom_range(0, 1 << 20);
                model_add(b, longint'(p));
                drive(1, b, p, i == n - 1);
                pb = b;
            end
            push_expected();
            collect(2, 0, 0);
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
                if (g !== e) begin n_err++; $display("FAIL back_to_back frame %0d word: got %h want %h", fr, g, e); end
            end
            exp_q.delete();
            n_cmp++; if (hs_cnt !== NF || !done_ok || done_cnt !== 1) begin n_err++; $display("FAIL back_to_back frame %0d transfers: got %0d done=%b want %0d done=1", fr, hs_cnt, done_ok, NF); end
        end
    endtask

    task automatic test_stall();
        logic [EW-1:0] e, g;
        for (int b = 0; b <= 36; b += 5) begin
            model_add(b, longint'(b * 100 + 7));
            drive(1, b, 32'(b * 100 + 7), b == 35);
        end
        push_expected();
        collect(1, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL stall order: got %h want %h", g, e); end
        end
        exp_q.delete();
        n_cmp++; if (stall_err !== 0 || stall_cnt == 0) begin n_err++; $display("FAIL stall stability: got %0d changes in %0d stalls want 0 changes", stall_err, stall_cnt); end
        n_cmp++; if (hs_cnt !== NF || !done_ok) begin n_err++; $display("FAIL stall transfers: got %0d done=%b want %0d done=1", hs_cnt, done_ok, NF); end
    endtask

    task automatic test_out_of_range();
        logic [EW-1:0] e, g;
        drive(1, 5, 32'd300, 0);
        model_add(5, 300);
        drive(1, 300, 32'd12345, 0);
        drive(1, 257, 32'd999, 0);
        drive(0, 0, 0, 0);
        n_cmp++; if (bus.overrun_o !== 1'b0) begin n_err++; $display("FAIL out_of_range overrun: got %b want 0", bus.overrun_o); end
        drive(0, 0, 0, 1);
        push_expected();
        collect(0, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL out_of_range word: got %h want %h", g, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_overrun();
        logic [EW-1:0] e, g;
        drive(1, 20, 32'd4444, 0);
        model_add(20, 4444);
        drive(1, 21, 32'd800, 1);
        model_add(21, 800);
        push_expected();
        collect(0, 0, 1);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL overrun word: got %h want %h", g, e); end
        end
        exp_q.delete();
        n_cmp++; if (bus.overrun_o !== 1'b1) begin n_err++; $display("FAIL overrun flag: got %b want 1", bus.overrun_o); end
        n_cmp++; if (hs_cnt !== NF || !done_ok) begin n_err++; $display("FAIL overrun transfers: got %0d done=%b want %0d done=1", hs_cnt, done_ok, NF); end
    endtask

    task automatic test_reset_mid_output();
        logic [EW-1:0] e, g;
        drive(1, 12, 32'd5000, 0);
        model_add(12, 5000);
        drive(1, 13, 32'd6000, 1);
        model_add(13, 6000);
        push_expected();
        collect(0, 5, 0);
        for (int i = 0; i < 5 && got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL mid_reset pre word: got %h want %h", g, e); end
        end
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.mel_valid_o, bus.mel_idx_o, bus.mel_data_o, bus.mel_done_o, bus.overrun_o} !== '0) begin
            n_err++; $display("FAIL mid_reset outputs: got v=%b i=%0d d=%h dn=%b ov=%b want all 0", bus.mel_valid_o, bus.mel_idx_o, bus.mel_data_o, bus.mel_done_o, bus.overrun_o);
        end
        rst_n = 1'b1;
        drive(1, 12, 32'd77, 1);
        model_add(12, 77);
        push_expected();
        collect(0, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL mid_reset next frame word: got %h want %h", g, e); end
        end
        exp_q.delete();
        n_cmp++; if (hs_cnt !== NF || !done_ok) begin n_err++; $display("FAIL mid_reset next frame transfers: got %0d done=%b want %0d done=1", hs_cnt, done_ok, NF); end
    endtask

    task automatic test_log_point();
        logic [EW-1:0] e, g;
        drive(1, 12, 32'h1800, 1);
        model_add(12, 32'h1800);
        push_expected();
        collect(0, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL log_point word: got %h want %h", g, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_saturation();
        logic [EW-1:0] e, g;
        for (int b = 0; b <= 256; b++) drive(1, b, 32'h8000_0000, b == 256);
        for (int f = 0; f < NF; f++) exp_q.push_back({FW'(f), exp_word(48'h1_0000_0000)});
        collect(0, 0, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL saturation word: got %h want %h", g, e); end
        end
        exp_q.delete();
        n_cmp++; if (hs_cnt !== NF || !done_ok) begin n_err++; $display("FAIL saturation transfers: got %0d done=%b want %0d done=1", hs_cnt, done_ok, NF); end
    endtask

    initial begin
        bus.power_valid_i  = 1'b0;
        bus.power_ptr_i    = '0;
        bus.power_sample_i = '0;
        bus.fft_done_i     = 1'b0;
        bus.mel_ready_i    = 1'b0;
        model_clear();
        test_reset();
        test_single_bin();
        test_empty_frame();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_overrun();
        test_reset_mid_output();
        test_log_point();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
